// File: rtl/apb_cmd_scheduler.sv
// apb_cmd_scheduler: round-robin read/write arbiter driving the bridge's single APB master command port.
// Latency: grant in the cycle eligibility is seen in IDLE, command the next cycle, done when the master returns to IDLE after DISABLE.
// Backpressure: a request is only eligible when its FIFO can absorb the whole burst; no grant while busy.
// Optional watchdog: define APB_SCHED_TIMEOUT_EN to add the TIMEOUT_CYCLES parameter and the sticky timeout_err output.
module apb_cmd_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 5,
  parameter logic [ADDR_WIDTH-1:0] APB_BASE  = 32'h0002_F000,
  parameter logic [ADDR_WIDTH-1:0] APB_LIMIT = 32'h0002_FFFF
`ifdef APB_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  input  logic [2:0]            rd_size,
  input  logic [CNT_WIDTH-1:0]  rd_fifo_space,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic [2:0]            wr_size,
  input  logic [CNT_WIDTH-1:0]  wr_data_cnt,
  output logic                  rd_grant,
  output logic                  wr_grant,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  rd_err,
  output logic                  wr_err,
  output logic [1:0]            apb_cmd,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [2:0]            cmd_size,
  input  logic [1:0]            apb_info,
  output logic                  busy
`ifdef APB_SCHED_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_DIS   = 2'b11;
  localparam logic [1:0] INFO_IDLE   = 2'b00;
  localparam logic [1:0] INFO_BUSY   = 2'b01;
  localparam logic [1:0] INFO_SWITCH = 2'b10;

  // one extra bit so a full-length burst (len+1 = 2**LEN_WIDTH) compares correctly
  localparam int CW = CNT_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_RELEASE, S_DECERR
  } state_t;

  state_t state, state_nxt;
  logic   serve_wr;   // last direction granted; also the direction currently in flight
  logic   rd_ok, wr_ok, pick_rd, pick_wr, in_win;
  logic [CW-1:0] rd_need, wr_need;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic   op_err;     // completion of the current op reports an error

  assign rd_need = CW'(rd_len) + CW'(1);
  assign wr_need = CW'(wr_len) + CW'(1);
  assign rd_ok   = rd_req && ({1'b0, rd_fifo_space} >= rd_need);
  assign wr_ok   = wr_req && ({1'b0, wr_data_cnt} >= wr_need);
  // on a tie the side not served last wins
  assign pick_rd = rd_ok && (!wr_ok || serve_wr);
  assign pick_wr = wr_ok && (!rd_ok || !serve_wr);
  assign sel_addr = pick_wr ? wr_addr : rd_addr;
  assign in_win   = (sel_addr >= APB_BASE) && (sel_addr <= APB_LIMIT);

`ifdef APB_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            op_to, active, to_hit;

  assign active = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_RELEASE);
  assign to_hit = active && !op_to && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign op_err = op_to;

  // watchdog: restarts on ISSUE entry, stops counting once it has fired for this op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      op_to       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        to_cnt <= '0;
        op_to  <= 1'b0;
      end else if (active && !op_to) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (to_hit) begin
        op_to       <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign op_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state: follow the master's status handshake through to completion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (pick_rd || pick_wr) state_nxt = in_win ? S_ISSUE : S_DECERR;
      S_ISSUE:     if (apb_info == INFO_BUSY) state_nxt = S_WAIT_DONE;
                   else if (apb_info == INFO_SWITCH) state_nxt = S_RELEASE;
      S_WAIT_DONE: if (apb_info == INFO_SWITCH) state_nxt = S_RELEASE;
      S_RELEASE:   if (apb_info == INFO_IDLE) state_nxt = S_IDLE;
      S_DECERR:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
`ifdef APB_SCHED_TIMEOUT_EN
    if (to_hit && (state != S_RELEASE)) state_nxt = S_RELEASE;
`endif
  end

  // outputs decoded from registered state; grants held off while reset is asserted
  always_comb begin
    apb_cmd  = CMD_IDLE;
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    rd_err   = 1'b0;
    wr_err   = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        rd_grant = pick_rd && !rst;
        wr_grant = pick_wr && !rst;
      end
      S_ISSUE:   apb_cmd = serve_wr ? CMD_WRITE : CMD_READ;
      S_RELEASE: begin
        apb_cmd = CMD_DIS;
        if (apb_info == INFO_IDLE) begin
          rd_done = !serve_wr;
          wr_done = serve_wr;
          rd_err  = !serve_wr && op_err;
          wr_err  = serve_wr && op_err;
        end
      end
      S_DECERR: begin
        rd_done = !serve_wr;
        wr_done = serve_wr;
        rd_err  = !serve_wr;
        wr_err  = serve_wr;
      end
      default: apb_cmd = CMD_IDLE;
    endcase
  end

  // capture the granted request and remember which side was served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr <= '0;
      cmd_len  <= '0;
      cmd_size <= '0;
      serve_wr <= 1'b1;
    end else if (state == S_IDLE && (pick_rd || pick_wr)) begin
      cmd_addr <= sel_addr;
      cmd_len  <= pick_wr ? wr_len : rd_len;
      cmd_size <= pick_wr ? wr_size : rd_size;
      serve_wr <= pick_wr;
    end
  end

endmodule
